// File: rtl/master_bus_arbiter_pkg.sv
// Shared types and constants for the master_module bus arbiter.
// The register map and STAT_REG bit layout mirror master_module's register port.
package master_arb_pkg;

    typedef enum logic [2:0] {IDLE, POLL, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] ADDR_FIFO = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_MEM  = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;

    // A FIFO write is refused when full, a FIFO read when empty.
    function automatic logic fifo_reject(input logic write, input logic [7:0] stat);
        return write ? stat[STAT_FULL_BIT] : stat[STAT_EMPTY_BIT];
    endfunction

endpackage

// File: rtl/master_bus_arbiter_if.sv
// Requester handshake plus master_module register port, bundled for the arbiter.
// slave: the arbiter's view; master: the clients and master_module side.
interface master_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_write;
    logic [2*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_rdata;
    logic                 rsp_err;
    logic                 m_enable;
    logic [1:0]           m_addr;
    logic                 m_write;
    logic                 m_read;
    logic [7:0]           m_wdata;
    logic [7:0]           m_rdata;
    logic                 m_resp;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, m_rdata, m_resp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_enable, m_addr, m_write, m_read, m_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, m_rdata, m_resp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_enable, m_addr, m_write, m_read, m_wdata
    );

endinterface

// File: rtl/master_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after pointer, with wrap.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic            enable,
    input  logic [IdxW-1:0] pointer,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            grant_valid
);

    int unsigned idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(pointer) + i;
            if (idx >= N) idx = idx - N;
            if (enable && !grant_valid && req[IdxW'(idx)]) begin
                grant_valid            = 1'b1;
                grant_idx              = IdxW'(idx);
                grant[IdxW'(idx)]      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/master_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one master_module register port among NUM_REQ clients.
// One transaction at a time; FIFO accesses are screened against STAT_REG first.
module master_bus_arbiter
    import master_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned RD_LAT  = 1
) (
    input logic                clk,
    input logic                rst,
    master_bus_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic            write_q, write_d;
    logic [1:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [IdxW-1:0]    grant_idx;
    logic               grant_valid;
    logic               arb_en;
    logic               sel_write;
    logic [1:0]         sel_addr;
    logic [7:0]         sel_wdata;

    logic               m_enable_c, m_write_c, m_read_c;
    logic [1:0]         m_addr_c;
    logic [7:0]         m_wdata_c;
    logic [NUM_REQ-1:0] rsp_valid_c;
    logic [7:0]         rsp_rdata_c;
    logic               rsp_err_c;

    // Gating with rst keeps req_ready low while reset is held.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req         (bus.req_valid),
        .enable      (arb_en),
        .pointer     (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_write = bus.req_write[grant_idx];
    assign sel_addr  = bus.req_addr[{grant_idx, 1'b0} +: 2];
    assign sel_wdata = bus.req_wdata[{grant_idx, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        m_enable_c  = 1'b0;
        m_addr_c    = 2'd0;
        m_write_c   = 1'b0;
        m_read_c    = 1'b0;
        m_wdata_c   = 8'd0;
        rsp_valid_c = '0;
        rsp_rdata_c = 8'd0;
        rsp_err_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = 1'b0;
                    rdata_d = 8'd0;
                    ptr_d   = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    case (sel_addr)
                        ADDR_FIFO: state_d = POLL;
                        ADDR_RSVD: begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                        default:   state_d = ISSUE;
                    endcase
                end
            end
            POLL: begin
                m_enable_c = 1'b1;
                m_read_c   = 1'b1;
                m_addr_c   = ADDR_STAT;
                if (fifo_reject(write_q, bus.m_rdata)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_enable_c = 1'b1;
                m_addr_c   = addr_q;
                m_write_c  = write_q;
                m_read_c   = !write_q;
                m_wdata_c  = write_q ? wdata_q : 8'd0;
                if (write_q) begin
                    if (addr_q == ADDR_MEM && !bus.m_resp) err_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CntW'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                m_addr_c = addr_q;
                if (cnt_q == '0) begin
                    rdata_d = bus.m_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid_c[owner_q] = 1'b1;
                rsp_rdata_c          = err_q ? 8'd0 : rdata_q;
                rsp_err_c            = err_q;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            write_q <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= 8'd0;
            err_q   <= 1'b0;
            rdata_q <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_rdata_c;
    assign bus.rsp_err   = rsp_err_c;
    assign bus.m_enable  = m_enable_c;
    assign bus.m_addr    = m_addr_c;
    assign bus.m_write   = m_write_c;
    assign bus.m_read    = m_read_c;
    assign bus.m_wdata   = m_wdata_c;

endmodule

// File: tb/tb_master_bus_arbiter.sv
// Bench for master_bus_arbiter: a small master_module model, a transaction-level reference
// model compared every cycle, and directed transactions with literal expectations.
module tb_master_bus_arbiter;
    import master_arb_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned FDEPTH  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    master_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    master_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // master_module model: 2-deep FIFO at addr 0, STAT at addr 1, MEM at addr 2.
    logic [7:0]  fifo_mem [FDEPTH];
    int unsigned fifo_cnt = 0;
    logic [7:0]  mem_val  = 8'd0;
    logic [7:0]  rd_reg   = 8'd0;
    logic        mem_ok   = 1'b1;
    logic [7:0]  stat_val;

    assign stat_val     = {6'd0, fifo_cnt == 0, fifo_cnt == FDEPTH};
    assign bus.m_rdata  = (bus.m_enable && bus.m_read && bus.m_addr == ADDR_STAT) ? stat_val : rd_reg;
    assign bus.m_resp   = bus.m_enable && bus.m_write && bus.m_addr == ADDR_MEM && mem_ok;

    initial forever begin
        @(posedge clk);
        if (!rst && bus.m_enable) begin
            if (bus.m_write) begin
                if (bus.m_addr == ADDR_FIFO && fifo_cnt < FDEPTH) begin
                    fifo_mem[fifo_cnt] = bus.m_wdata;
                    fifo_cnt++;
                end else if (bus.m_addr == ADDR_MEM) begin
                    mem_val = bus.m_wdata;
                end
            end else if (bus.m_read) begin
                case (bus.m_addr)
                    ADDR_FIFO: begin
                        rd_reg <= fifo_mem[0];
                        if (fifo_cnt > 0) begin
                            for (int unsigned i = 0; i + 1 < FDEPTH; i++) fifo_mem[i] = fifo_mem[i+1];
                            fifo_cnt--;
                        end
                    end
                    ADDR_STAT: rd_reg <= stat_val;
                    ADDR_MEM:  rd_reg <= mem_val;
                    default:   rd_reg <= 8'd0;
                endcase
            end
        end
    end

    // Reference model: one transaction planned as a timeline from its handshake.
    int          md_off = -1;
    int unsigned md_ptr = 0;
    int unsigned md_owner;
    logic        md_write, md_rej, md_err;
    logic [1:0]  md_addr;
    logic [7:0]  md_wdata, md_rdata;
    int          md_lat, md_issue;

    initial forever begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_vld;
        logic               found, ep_en, ep_wr, ep_rd;
        logic [1:0]         ep_addr;
        logic [7:0]         ep_wd;
        @(negedge clk);
        if (rst) begin
            chk("reset_outputs", 32'({bus.req_ready, bus.m_enable, bus.m_addr, bus.m_write,
                bus.m_read, bus.m_wdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 32'd0);
            md_off = -1;
            md_ptr = 0;
        end else if (md_off < 0) begin
            exp_ready = '0;
            found     = 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                int unsigned j;
                j = (md_ptr + i) % NUM_REQ;
                if (!found && bus.req_valid[j]) begin
                    found        = 1'b1;
                    exp_ready[j] = 1'b1;
                    md_owner     = j;
                end
            end
            chk("model_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("model_port_idle", 32'({bus.m_enable, bus.m_addr, bus.m_write, bus.m_read,
                bus.m_wdata}), 32'd0);
            chk("model_rsp_idle", 32'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 32'd0);
            if (found) begin
                md_write = bus.req_write[md_owner];
                md_addr  = bus.req_addr[2*md_owner +: 2];
                md_wdata = bus.req_wdata[8*md_owner +: 8];
                md_rej   = md_addr == ADDR_FIFO &&
                           (md_write ? fifo_cnt == FDEPTH : fifo_cnt == 0);
                md_issue = (md_addr == ADDR_FIFO) ? 2 : 1;
                md_rdata = 8'd0;
                if (md_addr == 2'd3) begin
                    md_lat = 1;
                    md_err = 1'b1;
                end else if (md_rej) begin
                    md_lat = 2;
                    md_err = 1'b1;
                end else begin
                    md_lat = md_issue + 1 + (md_write ? 0 : int'(RD_LAT));
                    md_err = md_write && md_addr == ADDR_MEM && !mem_ok;
                    if (!md_write)
                        md_rdata = (md_addr == ADDR_FIFO) ? fifo_mem[0] :
                                   (md_addr == ADDR_STAT) ? stat_val : mem_val;
                end
                md_ptr = (md_owner + 1) % NUM_REQ;
                md_off = 1;
            end
        end else begin
            ep_en = 1'b0; ep_addr = 2'd0; ep_wr = 1'b0; ep_rd = 1'b0; ep_wd = 8'd0;
            if (md_addr == ADDR_FIFO && md_off == 1) begin
                ep_en = 1'b1; ep_addr = ADDR_STAT; ep_rd = 1'b1;
            end else if (md_addr != 2'd3 && !md_rej && md_off == md_issue) begin
                ep_en = 1'b1; ep_addr = md_addr; ep_wr = md_write; ep_rd = !md_write;
                ep_wd = md_write ? md_wdata : 8'd0;
            end else if (md_addr != 2'd3 && !md_rej && !md_write && md_off > md_issue &&
                         md_off < md_lat) begin
                ep_addr = md_addr;
            end
            chk("model_ready_busy", 32'(bus.req_ready), 32'd0);
            chk("model_port", 32'({bus.m_enable, bus.m_addr, bus.m_write, bus.m_read, bus.m_wdata}),
                32'({ep_en, ep_addr, ep_wr, ep_rd, ep_wd}));
            if (md_off == md_lat) begin
                exp_vld           = '0;
                exp_vld[md_owner] = 1'b1;
                chk("model_rsp", 32'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}),
                    32'({exp_vld, md_rdata, md_err}));
                md_off = -1;
            end else begin
                chk("model_rsp_quiet", 32'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 32'd0);
                md_off++;
            end
        end
    end

    task automatic do_txn(input int idx, input logic wr, input logic [1:0] addr,
                          input logic [7:0] wd, input int exp_lat, input logic exp_err,
                          input logic [7:0] exp_rd, input string name);
        bit hs;
        int k;
        @(posedge clk); #1;
        bus.req_write[idx]        = wr;
        bus.req_addr[2*idx +: 2]  = addr;
        bus.req_wdata[8*idx +: 8] = wd;
        bus.req_valid[idx]        = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) hs = 1'b1;
        end
        if (!hs) begin
            chk({name, "_handshake"}, 32'd0, 32'd1);
            bus.req_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
        k = 21;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid[idx]) begin
                k = c;
                break;
            end
        end
        chk({name, "_latency"}, 32'(k), 32'(exp_lat));
        chk({name, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({name, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
    endtask

    int order [5];
    int gcyc  [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        bit hs;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        do_txn(0, 1'b1, ADDR_FIFO, 8'hA5, 3, 1'b0, 8'h00, "fifo_wr");
        do_txn(0, 1'b0, ADDR_FIFO, 8'h00, 4, 1'b0, 8'hA5, "fifo_rd");
        do_txn(0, 1'b0, ADDR_FIFO, 8'h00, 2, 1'b1, 8'h00, "fifo_rd_empty");
        do_txn(0, 1'b1, ADDR_FIFO, 8'h11, 3, 1'b0, 8'h00, "fifo_fill1");
        do_txn(0, 1'b1, ADDR_FIFO, 8'h22, 3, 1'b0, 8'h00, "fifo_fill2");
        do_txn(0, 1'b1, ADDR_FIFO, 8'h33, 2, 1'b1, 8'h00, "fifo_wr_full");
        do_txn(0, 1'b1, ADDR_MEM,  8'h3C, 2, 1'b0, 8'h00, "mem_wr");
        do_txn(0, 1'b0, ADDR_MEM,  8'h00, 3, 1'b0, 8'h3C, "mem_rd");
        do_txn(0, 1'b0, ADDR_STAT, 8'h00, 3, 1'b0, 8'h01, "stat_rd_full");
        do_txn(0, 1'b0, ADDR_FIFO, 8'h00, 4, 1'b0, 8'h11, "fifo_rd_order");
        mem_ok = 1'b0;
        do_txn(0, 1'b1, ADDR_MEM,  8'h77, 2, 1'b1, 8'h00, "mem_wr_nack");
        mem_ok = 1'b1;
        do_txn(2, 1'b0, 2'd3,      8'h00, 1, 1'b1, 8'h00, "rsvd_rd");
        do_txn(3, 1'b1, 2'd3,      8'hFF, 1, 1'b1, 8'h00, "rsvd_wr");

        // All four requesters held valid: pointer is back at 0 after the grant to 3.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus.req_write[i]       = 1'b1;
            bus.req_addr[2*i +: 2] = ADDR_MEM;
            bus.req_wdata[8*i +: 8] = 8'h10 + 8'(i);
            order[i] = -1;
        end
        order[4] = -1;
        bus.req_valid = '1;
        n   = 0;
        cyc = 0;
        while (n < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (n < 5 && bus.req_valid[i] && bus.req_ready[i]) begin
                    order[n] = i;
                    gcyc[n]  = cyc;
                    n++;
                end
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) chk("grant_order", 32'(order[i]), 32'(exp_order[i]));
        chk("grant_spacing", 32'(gcyc[1] - gcyc[0]), 32'd3);
        repeat (4) @(negedge clk);

        // Reset while a read of MEM waits for its data.
        @(posedge clk); #1;
        bus.req_write[1]       = 1'b0;
        bus.req_addr[2 +: 2]   = ADDR_MEM;
        bus.req_valid[1]       = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk);
            if (bus.req_ready[1]) hs = 1'b1;
        end
        chk("rst_txn_handshake", 32'(hs), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        chk("rst_txn_issue", 32'({bus.m_enable, bus.m_read, bus.m_addr}), 32'hE);
        @(posedge clk); #1;
        chk("rst_txn_wait", 32'({bus.m_enable, bus.m_read, bus.m_addr}), 32'h2);
        rst = 1'b1;
        #1;
        chk("rst_outputs_now", 32'({bus.req_ready, bus.m_enable, bus.m_addr, bus.m_write,
            bus.m_read, bus.m_wdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn(1, 1'b1, ADDR_MEM, 8'h5A, 2, 1'b0, 8'h00, "after_rst");
        do_txn(1, 1'b0, ADDR_MEM, 8'h00, 3, 1'b0, 8'h5A, "after_rst_rd");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
